noc_xbar_router: RTL
====================

NOC_XBAR_ROUTER -- requirements
Module: noc_xbar_router

Interface
REQ-001 Parameter NPORTS, default 16: number of input and output ports; power of two, 2..16.
REQ-002 Parameter DW, default 8: flit width in bits; DW >= 2*log2(NPORTS).
REQ-003 Parameter FIFO_DEPTH, default 4: flits per input FIFO; power of two, >= 2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 data_i  in  NPORTS*DW  input flits, port p at bits [p*DW +: DW].
REQ-007 wr_i  in  NPORTS  per-port write strobe, sampled on rising clk.
REQ-008 datao  out  NPORTS*DW  output flits, same packing as data_i.
REQ-009 valid_o  out  NPORTS  per-output flit-valid, one-cycle pulse per flit.
REQ-010 full_o  out  NPORTS  per-input FIFO full.
REQ-011 ovf_o  out  NPORTS  per-input one-cycle pulse on dropped write.

Function
REQ-012 Each flit is a single-flit packet; destination = flit bits [log2(NPORTS)-1:0]; bits [2*log2(NPORTS)-1:log2(NPORTS)] = source tag, carried unmodified.
REQ-013 wr_i[p]=1 with full_o[p]=0 SHALL push data_i[p] into FIFO p at that edge.
REQ-014 wr_i[p]=1 with full_o[p]=1 SHALL drop the flit and pulse ovf_o[p] on the next cycle; full is from pre-edge occupancy, so a simultaneous pop does not admit the write.
REQ-015 full_o[p] = (occupancy == FIFO_DEPTH), registered; pointers wrap modulo FIFO_DEPTH.
REQ-016 Each cycle, per output o, an arbiter SHALL grant one non-empty input whose head destination is o; the granted head is popped at the same edge that loads datao[o] and sets valid_o[o].
REQ-017 An input head targets exactly one output, so each FIFO pops at most once per cycle; no output backpressure exists.
REQ-018 Uncontended latency: flit written at edge k appears on datao/valid_o after edge k+1 (2 edges total).
REQ-019 Output o with no grant SHALL drive valid_o[o]=0 and datao[o]=0.
REQ-020 Round-robin: per-output pointer rr[o]; search starts at input rr[o] ascending with wrap; after a grant to input i, rr[o] = (i+1) mod NPORTS; no grant leaves rr[o] unchanged.
REQ-021 Flits from one input to one output SHALL leave in write order; none duplicated or lost except per REQ-014.

Reset
REQ-022 reset=0 SHALL immediately empty all FIFOs, clear rr[] to 0, and force datao, valid_o, full_o, ovf_o to 0.
REQ-023 Flits in flight at reset assertion are discarded; the first wr_i sampled after release SHALL be accepted normally.

Configuration
REQ-024 Macro NOC_RR_ARB_EN: defined -> round-robin per REQ-020; undefined -> fixed priority, lowest requesting input index wins, rr[] not instantiated.

Structure
REQ-025 Package noc_pkg SHALL hold default NPORTS/DW/FIFO_DEPTH constants, address-width localparam function, and the destination/source field position constants.
REQ-026 Sub-module noc_fifo (synchronous FIFO with push/pop/full/empty/head) SHALL be instantiated once per input; arbitration and crossbar mux stay in noc_xbar_router.

Verification (NPORTS=16, DW=8, FIFO_DEPTH=4)
REQ-027 wr_i[1]=1, data 8'h17, one cycle -> datao[7]=8'h17, valid_o[7]=1 one cycle after edge k+1; all other valid_o=0.
REQ-028 Same edge: port 2 writes 8'h24, port 5 writes 8'h54, RR on, rr[4]=0 -> output 4 carries 8'h24 then 8'h54 on consecutive cycles; rr[4]=6 afterwards.
REQ-029 Ports 0 and 1 write dest 0 every cycle for 12 cycles -> output 0 alternates port 0/port 1 sources, full_o[0] and full_o[1] assert, ovf_o pulses per dropped write; accepted+dropped = 24, order per source preserved.
REQ-030 NOC_RR_ARB_EN undefined, ports 3 and 9 each continuously send to dest 2 -> only port 3 flits appear until port 3 stops; port 9 fills, full_o[9]=1.
REQ-031 Load 3 flits into FIFO 6 with dest output busy, assert reset mid-transfer -> all outputs 0 immediately; after release no stale flit appears; new write 8'h6A yields datao[10]=8'h6A two edges later.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and helpers for the NoC crossbar router.
// Default geometry: 16 ports, 8-bit flits, 4-deep input FIFOs.
// A flit carries its destination in the low bits and its source tag directly above.
package noc_pkg;

  localparam int NOC_NPORTS     = 16;
  localparam int NOC_DW         = 8;
  localparam int NOC_FIFO_DEPTH = 4;

  // Destination field always starts at bit 0 of the flit.
  localparam int NOC_DST_LSB = 0;

  // Number of bits needed to address n ports (ceil(log2(n))).
  function automatic int noc_addr_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Source tag sits immediately above the destination field.
  function automatic int noc_src_lsb(input int aw);
    return NOC_DST_LSB + aw;
  endfunction

  // Source tag position for the default port count.
  localparam int NOC_SRC_LSB = NOC_DST_LSB + noc_addr_w(NOC_NPORTS);

endpackage

// File: rtl/noc_fifo.sv
// Synchronous input FIFO holding flits for one router input.
// Latency: a pushed flit is visible on head the cycle after the push edge.
// Backpressure: push is ignored while full (registered); pop is ignored while empty.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DW    = NOC_DW,
  parameter int DEPTH = NOC_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // Full comes from the pre-edge occupancy, so a same-cycle pop cannot admit a write.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Next occupancy, used to register the full flag.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Flit storage; contents are only observed once the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/noc_xbar_router.sv
// Single-flit-packet crossbar: per-input FIFOs, per-output arbiter, registered outputs.
// Latency: flit written at edge k appears on datao/valid_o after edge k+1.
// Backpressure: none on outputs; writes to a full input are dropped and flagged on ovf_o.
// Build option: define NOC_RR_ARB_EN for round-robin arbitration, otherwise lowest input wins.
module noc_xbar_router
  import noc_pkg::*;
#(
  parameter int NPORTS     = NOC_NPORTS,
  parameter int DW         = NOC_DW,
  parameter int FIFO_DEPTH = NOC_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS*DW-1:0] data_i,
  input  logic [NPORTS-1:0]    wr_i,
  output logic [NPORTS*DW-1:0] datao,
  output logic [NPORTS-1:0]    valid_o,
  output logic [NPORTS-1:0]    full_o,
  output logic [NPORTS-1:0]    ovf_o
);

  localparam int AW = noc_addr_w(NPORTS);

  logic [DW-1:0]     head     [NPORTS];
  logic [AW-1:0]     head_dst [NPORTS];
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] req      [NPORTS];
  logic [NPORTS-1:0] gnt_vld;
  logic [AW-1:0]     gnt_idx  [NPORTS];

`ifdef NOC_RR_ARB_EN
  logic [AW-1:0]     rr       [NPORTS];
`endif

  // One FIFO per input; its own full flag gates the write.
  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    noc_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_i[p]),
      .pop   (pop[p]),
      .din   (data_i[p*DW +: DW]),
      .head  (head[p]),
      .full  (full_o[p]),
      .empty (empty[p])
    );
    assign head_dst[p] = head[p][NOC_DST_LSB +: AW];
  end

  // Request matrix: req[o][i] when input i holds a head flit bound for output o.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = !empty[i] && (head_dst[i] == AW'(o));
      end
    end
  end

  // Per-output arbiter: scan inputs from the start point with wrap, take the first requester.
  always_comb begin
    logic [AW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int o = 0; o < NPORTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      found      = 1'b0;
      for (int k = 0; k < NPORTS; k++) begin
`ifdef NOC_RR_ARB_EN
        idx = rr[o] + AW'(k);
`else
        idx = AW'(k);
`endif
        if (!found && req[o][idx]) begin
          found      = 1'b1;
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx;
        end
      end
    end
  end

  // A head targets one output only, so each FIFO sees at most one pop per cycle.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  // Crossbar output registers: granted head flit, or zeros when the output is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      datao   <= '0;
      valid_o <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        valid_o[o]          <= gnt_vld[o];
        datao[o*DW +: DW]   <= gnt_vld[o] ? head[gnt_idx[o]] : '0;
      end
    end
  end

  // Overflow pulse one cycle after a write hits a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_o <= '0;
    end else begin
      ovf_o <= wr_i & full_o;
    end
  end

`ifdef NOC_RR_ARB_EN
  // Round-robin pointers move just past the last granted input; idle outputs keep theirs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NPORTS; o++) rr[o] <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt_vld[o]) rr[o] <= gnt_idx[o] + AW'(1);
      end
    end
  end
`endif

endmodule
